dm_port_arbiter: RTL

//  Shares the single-port data memory (dm_1k) between the multicycle CPU's MEM step and an

---
 rtl/dm_port_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/dm_port_arbiter.sv
// Arbitrates dm_1k between CPU and external ports; partial writes become read-modify-write.
// Config macro DM_ARB_RR_EN: round-robin on contention (default fixed CPU priority). Latency rd 2 / full wr 2 / partial wr 3 / be=0 1.
module dm_port_arbiter #(
   parameter int AW = 10,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [DW/8-1:0] cpu_be,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_ack,
   input  logic          ext_req,
   input  logic          ext_we,
   input  logic [DW/8-1:0] ext_be,
   input  logic [AW-1:0] ext_addr,
   input  logic [DW-1:0] ext_wdata,
   output logic [DW-1:0] ext_rdata,
   output logic          ext_ack,
   output logic [AW-1:0] dm_addr,
   output logic [DW-1:0] dm_din,
   output logic          dm_we,
   input  logic [DW-1:0] dm_dout
);
   localparam int NB = DW / 8;
   localparam logic GNT_CPU = 1'b0;
   localparam logic GNT_EXT = 1'b1;

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_ACK} state_t;
   state_t r_state, w_next;

   logic          r_owner;
   logic          r_we;
   logic          r_last_gnt;
   logic [NB-1:0] r_be;
   logic [AW-3:0] r_addr;
   logic [DW-1:0] r_wdata;
   logic [DW-1:0] r_rbuf;
   logic [DW-1:0] r_cpu_rdata;
   logic [DW-1:0] r_ext_rdata;

   logic          w_any_req;
   logic          w_pick_ext;
   logic          w_sel_we;
   logic [NB-1:0] w_sel_be;
   logic [AW-3:0] w_sel_addr;
   logic [DW-1:0] w_sel_wdata;
   logic          w_unused;

   // Byte offset is dropped (word access); last_gnt is only consulted in the round-robin build.
   assign w_unused  = ^{cpu_addr[1:0], ext_addr[1:0], r_last_gnt};
   assign w_any_req = cpu_req | ext_req;

   always_comb begin
      w_pick_ext = 1'b0;
`ifdef DM_ARB_RR_EN
      if (cpu_req && ext_req)
         w_pick_ext = (r_last_gnt == GNT_CPU);
      else
         w_pick_ext = ext_req;
`else
      w_pick_ext = ext_req && !cpu_req;
`endif
   end

   assign w_sel_we    = w_pick_ext ? ext_we    : cpu_we;
   assign w_sel_be    = w_pick_ext ? ext_be    : cpu_be;
   assign w_sel_addr  = w_pick_ext ? ext_addr[AW-1:2] : cpu_addr[AW-1:2];
   assign w_sel_wdata = w_pick_ext ? ext_wdata : cpu_wdata;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_any_req) begin
               if (!w_sel_we)
                  w_next = S_RD;
               else if (w_sel_be == {NB{1'b1}})
                  w_next = S_WR;
               else if (w_sel_be == '0)
                  w_next = S_ACK;
               else
                  w_next = S_RD;
            end
         end
         S_RD:    w_next = r_we ? S_WR : S_ACK;
         S_WR:    w_next = S_ACK;
         S_ACK:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Lanes not enabled are refilled from the word read in RD.
   always_comb begin
      dm_din = '0;
      if (r_state == S_WR) begin
         for (int i = 0; i < NB; i++)
            dm_din[8*i +: 8] = r_be[i] ? r_wdata[8*i +: 8] : r_rbuf[8*i +: 8];
      end
   end

   assign dm_we     = (r_state == S_WR);
   assign dm_addr   = {r_addr, 2'b00};
   assign cpu_ack   = (r_state == S_ACK) && (r_owner == GNT_CPU);
   assign ext_ack   = (r_state == S_ACK) && (r_owner == GNT_EXT);
   assign cpu_rdata = r_cpu_rdata;
   assign ext_rdata = r_ext_rdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_owner     <= GNT_CPU;
         r_we        <= 1'b0;
         r_last_gnt  <= GNT_EXT;
         r_be        <= '0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_rbuf      <= '0;
         r_cpu_rdata <= '0;
         r_ext_rdata <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_owner <= w_pick_ext;
                  r_we    <= w_sel_we;
                  r_be    <= w_sel_be;
                  r_addr  <= w_sel_addr;
                  r_wdata <= w_sel_wdata;
               end
            end
            S_RD: begin
               r_rbuf <= dm_dout;
               if (!r_we) begin
                  if (r_owner == GNT_EXT)
                     r_ext_rdata <= dm_dout;
                  else
                     r_cpu_rdata <= dm_dout;
               end
            end
            S_ACK:   r_last_gnt <= r_owner;
            default: ;
         endcase
      end
   end
endmodule
